// File: rtl/bcm_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcm_scan_ctrl
// Scan controller for chained 32x16 HUB75-style LED panels driven with
// binary-code modulation (BCM). For each row and bit plane it shifts one line
// of pixels (sclk), blanks, latches, then holds the LEDs on for a time that
// doubles with each bit plane.
//
// Build option:
//   BCM_SCAN_BCM_EN  defined   : four bit planes, ON time = BASE_TICKS << plane
//                    undefined : single plane (plane output stays 0),
//                                ON time = BASE_TICKS, every pass advances row
//
// Parameters:
//   NUM_PANELS   panels chained; columns shifted per row = 32*NUM_PANELS (<=256)
//   BASE_TICKS   ON cycles of the least-significant bit plane
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       scan run request (sampled in IDLE and at the end of ON)
//   row          row being shifted, to pixel source
//   col          column being shifted, to pixel source
//   plane        bit plane being shifted, to pixel source
//   disp_row     row address driven to the panel
//   sclk         panel shift clock
//   blank        panel output blank (1 = LEDs off)
//   lat          panel latch strobe
//   frame_start  one-cycle pulse on the first shift cycle of row 0 / plane 0
// -----------------------------------------------------------------------------
module bcm_scan_ctrl #(
    parameter int unsigned NUM_PANELS = 4,
    parameter int unsigned BASE_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [2:0] row,
    output logic [7:0] col,
    output logic [1:0] plane,
    output logic [2:0] disp_row,
    output logic       sclk,
    output logic       blank,
    output logic       lat,
    output logic       frame_start
);

    localparam int unsigned NCOL  = 32 * NUM_PANELS;
    localparam int unsigned CNT_W = 16;
    localparam logic [7:0]       COL_LAST = 8'(NCOL - 1);
    localparam logic [CNT_W-1:0] BASE     = CNT_W'(BASE_TICKS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        BLANK = 3'd2,
        LATCH = 3'd3,
        ON    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       row_nxt;
    logic [7:0]       col_nxt;
    logic [1:0]       plane_nxt;
    logic [2:0]       disp_row_nxt;
    logic             sclk_nxt;
    logic             blank_nxt;
    logic             lat_nxt;
    logic             frame_start_nxt;
    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] on_cnt_nxt;
    logic [CNT_W-1:0] on_len;

    // ON duration for the plane about to be displayed
    always_comb begin
`ifdef BCM_SCAN_BCM_EN
        on_len = BASE << plane;
`else
        on_len = BASE;
`endif
    end

    // State and registered outputs; outputs always describe the current state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            plane       <= '0;
            disp_row    <= '0;
            sclk        <= 1'b0;
            blank       <= 1'b1;
            lat         <= 1'b0;
            frame_start <= 1'b0;
            on_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            plane       <= plane_nxt;
            disp_row    <= disp_row_nxt;
            sclk        <= sclk_nxt;
            blank       <= blank_nxt;
            lat         <= lat_nxt;
            frame_start <= frame_start_nxt;
            on_cnt      <= on_cnt_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nxt       = state;
        row_nxt         = row;
        col_nxt         = col;
        plane_nxt       = plane;
        disp_row_nxt    = disp_row;
        sclk_nxt        = 1'b0;
        blank_nxt       = blank;
        lat_nxt         = 1'b0;
        frame_start_nxt = 1'b0;
        on_cnt_nxt      = on_cnt;

        case (state)
            IDLE: begin
                blank_nxt = 1'b1;
                if (enable) begin
                    state_nxt       = SHIFT;
                    row_nxt         = '0;
                    col_nxt         = '0;
                    plane_nxt       = '0;
                    frame_start_nxt = 1'b1;
                end
            end

            // Two cycles per column: sclk low then high; blank is left alone
            // so the panel keeps showing the previously latched line.
            SHIFT: begin
                if (!sclk) begin
                    sclk_nxt = 1'b1;
                end else if (col == COL_LAST) begin
                    col_nxt   = '0;
                    state_nxt = BLANK;
                    blank_nxt = 1'b1;
                end else begin
                    col_nxt = col + 8'd1;
                end
            end

            BLANK: begin
                state_nxt = LATCH;
                blank_nxt = 1'b1;
                lat_nxt   = 1'b1;
            end

            // Row address changes while the LEDs are dark, right before ON
            LATCH: begin
                state_nxt    = ON;
                blank_nxt    = 1'b0;
                disp_row_nxt = row;
                on_cnt_nxt   = on_len - CNT_W'(1);
            end

            ON: begin
                if (on_cnt != '0) begin
                    on_cnt_nxt = on_cnt - CNT_W'(1);
                end else if (!enable) begin
                    state_nxt = IDLE;
                    blank_nxt = 1'b1;
                end else begin
                    state_nxt = SHIFT;
`ifdef BCM_SCAN_BCM_EN
                    if (plane != 2'd3) begin
                        plane_nxt = plane + 2'd1;
                    end else begin
                        plane_nxt = '0;
                        row_nxt   = row + 3'd1;
                    end
`else
                    plane_nxt = '0;
                    row_nxt   = row + 3'd1;
`endif
                    frame_start_nxt = (row_nxt == 3'd0) && (plane_nxt == 2'd0);
                end
            end

            default: begin
                state_nxt = IDLE;
                blank_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_bcm_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcm_scan_ctrl
// Scoreboard bench for bcm_scan_ctrl. The stimulus process queues the expected
// scan passes (row, plane, ON length) and frame_start periods; an independent
// monitor reconstructs each pass from the panel pins and compares.
// -----------------------------------------------------------------------------
module tb_bcm_scan_ctrl;

    localparam int NCOL = 128;
`ifdef BCM_SCAN_BCM_EN
    localparam int NPL   = 4;
    localparam int FRAME = 10176;
`else
    localparam int NPL   = 1;
    localparam int FRAME = 2192;
`endif
    localparam int DROP_PLANE = (NPL > 1) ? 1 : 0;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] row;
    logic [7:0] col;
    logic [1:0] plane;
    logic [2:0] disp_row;
    logic       sclk;
    logic       blank;
    logic       lat;
    logic       frame_start;

    bcm_scan_ctrl #(
        .NUM_PANELS (4),
        .BASE_TICKS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .row         (row),
        .col         (col),
        .plane       (plane),
        .disp_row    (disp_row),
        .sclk        (sclk),
        .blank       (blank),
        .lat         (lat),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int plane;
        int on_len;
    } pass_t;

    pass_t exp_pass_q[$];
    int    exp_fs_q[$];
    int    on_tab[4];
    int    n_cmp;
    int    n_bad;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pass(input int r, input int p);
        pass_t e;
        e.row    = r;
        e.plane  = p;
        e.on_len = on_tab[p];
        exp_pass_q.push_back(e);
    endtask

    task automatic emit_pass(input int r, input int p, input int d, input int rises,
                             input int span, input int gap_ok, input int col_ok,
                             input int lat_blank, input int on_len);
        pass_t e;
        check("pass_expected", int'(exp_pass_q.size() != 0), 1);
        if (exp_pass_q.size() != 0) begin
            e = exp_pass_q.pop_front();
            check("pass_row", r, e.row);
            check("pass_plane", p, e.plane);
            check("pass_disp_row", d, e.row);
            check("pass_sclk_rises", rises, NCOL);
            check("pass_shift_span", span, 2 * NCOL);
            check("pass_blank_gap", gap_ok, 1);
            check("pass_col_seq", col_ok, 1);
            check("pass_latch_blank", lat_blank, 1);
            check("pass_on_len", on_len, e.on_len);
        end
    endtask

    // Monitor: rebuilds each shift/latch/on pass from the pins
    initial begin : monitor
        int cyc, ph, rises, first_rise, last_rise, on_cnt, last_fs, p;
        int lat_row, lat_plane, span, disp, gap_ok, col_ok, lat_blank, first_on;
        logic       prev_sclk, prev_blank, prev_lat, prev_fs;
        logic [7:0] prev_col;
        cyc = 0; ph = 0; rises = 0; first_rise = 0; last_rise = 0; on_cnt = 0;
        last_fs = 0; lat_row = 0; lat_plane = 0; span = 0; disp = 0;
        gap_ok = 0; col_ok = 0; lat_blank = 0; first_on = 0;
        prev_sclk = 1'b0; prev_blank = 1'b1; prev_lat = 1'b0; prev_fs = 1'b0;
        prev_col = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                ph = 0;
            end else begin
                if (frame_start) begin
                    check("fs_width", int'(prev_fs), 0);
                    check("fs_row", int'(row), 0);
                    check("fs_plane", int'(plane), 0);
                    check("fs_col", int'(col), 0);
                    check("fs_sclk", int'(sclk), 0);
                    check("fs_expected", int'(exp_fs_q.size() != 0), 1);
                    if (exp_fs_q.size() != 0) begin
                        p = exp_fs_q.pop_front();
                        if (p != 0) check("fs_period", cyc - last_fs, p);
                    end
                    last_fs = cyc;
                end
                if (ph == 2) begin
                    if (first_on != 0) begin
                        disp = int'(disp_row);
                        first_on = 0;
                    end
                    if (blank) begin
                        emit_pass(lat_row, lat_plane, disp, rises, span, gap_ok,
                                  col_ok, lat_blank, on_cnt);
                        ph = 0;
                    end else if (sclk) begin
                        // the cycle before this rise was the first shift cycle
                        emit_pass(lat_row, lat_plane, disp, rises, span, gap_ok,
                                  col_ok, lat_blank, on_cnt - 1);
                        ph = 0;
                    end else begin
                        on_cnt++;
                    end
                end
                if (ph != 2 && sclk && !prev_sclk) begin
                    if (ph == 0) begin
                        ph = 1;
                        rises = 0;
                        col_ok = 1;
                        first_rise = cyc;
                    end
                    rises++;
                    if (int'(col) != rises - 1 || prev_col != col) col_ok = 0;
                    last_rise = cyc;
                end else if (ph == 1 && lat) begin
                    lat_row   = int'(row);
                    lat_plane = int'(plane);
                    lat_blank = int'(blank);
                    span      = cyc - first_rise;
                    gap_ok    = int'(prev_blank && !prev_sclk && !prev_lat &&
                                     (last_rise == cyc - 2));
                    ph = 2;
                    on_cnt = 0;
                    first_on = 1;
                end
            end
            prev_sclk  = sclk;
            prev_blank = blank;
            prev_lat   = lat;
            prev_fs    = frame_start;
            prev_col   = col;
        end
    end

    // Stimulus
    initial begin : stim
        int bad, i;
        n_cmp = 0;
        n_bad = 0;
        on_tab[0] = 16; on_tab[1] = 32; on_tab[2] = 64; on_tab[3] = 128;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset with enable low
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (blank !== 1'b1 || sclk !== 1'b0 || lat !== 1'b0 || row !== 3'd0 ||
                col !== 8'd0 || plane !== 2'd0 || frame_start !== 1'b0 ||
                disp_row !== 3'd0) bad++;
        end
        check("rst_blank", int'(blank), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_lat", int'(lat), 0);
        check("rst_row", int'(row), 0);
        check("rst_col", int'(col), 0);
        check("rst_plane", int'(plane), 0);
        check("idle_stable_cycles_bad", bad, 0);

        // Free run two frames, then drop enable mid-shift of row 3
        exp_fs_q.push_back(0);
        exp_fs_q.push_back(FRAME);
        exp_fs_q.push_back(FRAME);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 8; r++)
                for (int pl = 0; pl < NPL; pl++) push_pass(r, pl);
        for (int r = 0; r < 3; r++)
            for (int pl = 0; pl < NPL; pl++) push_pass(r, pl);
        for (int pl = 0; pl <= DROP_PLANE; pl++) push_pass(3, pl);

        @(posedge clk);
        #1 enable = 1'b1;
        repeat (2 * FRAME - 10) @(posedge clk);
        @(negedge clk);
        i = 0;
        while (!(row == 3'd3 && plane == 2'(DROP_PLANE) && sclk == 1'b1) && i < FRAME) begin
            @(negedge clk);
            i++;
        end
        check("wait_drop_point", int'(row == 3'd3 && plane == 2'(DROP_PLANE) && sclk == 1'b1), 1);
        @(posedge clk);
        #1 enable = 1'b0;

        i = 0;
        while (exp_pass_q.size() != 0 && i < 4000) begin
            @(negedge clk);
            i++;
        end
        check("drain_after_drop", exp_pass_q.size(), 0);
        repeat (10) @(negedge clk);
        check("drop_idle_blank", int'(blank), 1);
        check("drop_idle_sclk", int'(sclk), 0);
        check("drop_idle_lat", int'(lat), 0);
        check("fs_q_after_drop", exp_fs_q.size(), 0);

        // Re-enable: restart at row 0 plane 0 with a frame_start pulse
        exp_fs_q.push_back(0);
        for (int k = 0; k < 2; k++) push_pass(k / NPL, k % NPL);
        @(posedge clk);
        #1 enable = 1'b1;
        i = 0;
        while (exp_pass_q.size() != 0 && i < 4000) begin
            @(negedge clk);
            i++;
        end
        check("drain_after_restart", exp_pass_q.size(), 0);
        check("fs_q_after_restart", exp_fs_q.size(), 0);

        // Reset in the middle of the third pass's ON period
        i = 0;
        while (lat !== 1'b1 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        check("wait_third_latch", int'(lat), 1);
        repeat (8) @(posedge clk);
        check("pre_rst_in_on", int'(blank), 0);
        #1 begin
            rst = 1'b1;
            enable = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midon_rst_blank", int'(blank), 1);
        check("midon_rst_sclk", int'(sclk), 0);
        check("midon_rst_lat", int'(lat), 0);
        check("midon_rst_row", int'(row), 0);
        check("midon_rst_col", int'(col), 0);
        check("midon_rst_plane", int'(plane), 0);
        check("midon_rst_disp_row", int'(disp_row), 0);
        check("midon_rst_fs", int'(frame_start), 0);

        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (blank !== 1'b1 || sclk !== 1'b0 || lat !== 1'b0) bad++;
        end
        check("post_rst_idle_bad", bad, 0);
        check("final_pass_q", exp_pass_q.size(), 0);
        check("final_fs_q", exp_fs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcm_scan_ctrl.md
BCM_SCAN_CTRL -- requirements
Module: bcm_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_PANELS, default 4: number of 32x16 panels chained; column count NCOL = 32*NUM_PANELS (max 256).
REQ-002 SHALL have parameter BASE_TICKS, default 16: clk cycles of display-on time for the least-significant bit plane.
REQ-003 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: enable  in  1  scan run request.
REQ-006 Port: row  out  3  row address currently being shifted, to pixel source.
REQ-007 Port: col  out  8  column index currently being shifted, to pixel source.
REQ-008 Port: plane  out  2  bit plane currently being shifted, to pixel source.
REQ-009 Port: disp_row  out  3  row address driven to the panel.
REQ-010 Port: sclk  out  1  panel shift clock.
REQ-011 Port: blank  out  1  panel output blank (1 = LEDs off).
REQ-012 Port: lat  out  1  panel latch strobe.
REQ-013 Port: frame_start  out  1  one-cycle pulse at start of each frame.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, BLANK, LATCH, ON.
REQ-015 IDLE: blank=1, sclk=0, lat=0; when enable=1, next state SHIFT with row=0, plane=0, col=0.
REQ-016 SHIFT: each col value held 2 cycles, sclk=0 in first, 1 in second; col increments after the sclk=1 cycle; SHIFT lasts exactly 2*NCOL cycles.
REQ-017 SHIFT: blank keeps its previous value (panel continues displaying prior latched data while shifting).
REQ-018 After the sclk=1 cycle of col=NCOL-1: col returns to 0, next state BLANK.
REQ-019 BLANK: 1 cycle, blank=1, lat=0, sclk=0.
REQ-020 LATCH: 1 cycle, blank=1, lat=1, sclk=0; disp_row loads row on exit.
REQ-021 ON: blank=0, lat=0, sclk=0 for exactly BASE_TICKS<<plane cycles (16-bit counter).
REQ-022 Exit of ON: if enable=0 go IDLE; else if plane<3, plane+1, same row, go SHIFT; else plane=0, row+1 (7 wraps to 0), go SHIFT.
REQ-023 frame_start SHALL be 1 exactly in the first SHIFT cycle of row=0, plane=0, else 0.
REQ-024 enable SHALL be sampled only in IDLE and at exit of ON; deassertion elsewhere has no effect until ON completes.
REQ-025 Re-entry from IDLE always restarts at row=0, plane=0 with frame_start pulse.
REQ-026 Row period (BCM on, NUM_PANELS=4, BASE_TICKS=16): 4*(256+2)+16*15 = 1272 cycles; frame = 10176 cycles.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, row=0, col=0, plane=0, disp_row=0, sclk=0, lat=0, blank=1, frame_start=0, on-counter=0.
REQ-028 rst SHALL override all activity in any state, including mid-SHIFT and mid-ON.

Configuration
REQ-029 Macro BCM_SCAN_BCM_EN defined: four bit planes, ON time BASE_TICKS<<plane per REQ-021/022.
REQ-030 Macro BCM_SCAN_BCM_EN undefined: single plane; plane output tied 0; ON always BASE_TICKS cycles; every ON exit advances row; row period 256+2+16 = 274, frame 2192 cycles.

Verification
REQ-031 rst held 3 cycles, enable=0 -> blank=1, sclk=0, lat=0, row=col=plane=0, remains IDLE indefinitely.
REQ-032 enable=1 from IDLE -> frame_start pulse 1 cycle, 256 SHIFT cycles with 128 sclk rising edges, col 0..127 each held 2 cycles.
REQ-033 After SHIFT -> exactly 1 BLANK cycle, 1 LATCH cycle with lat=1, blank=1; disp_row=row next cycle; ON blank=0 for 16,32,64,128 cycles for planes 0..3.
REQ-034 Free-run 2 frames -> frame_start period exactly 10176 cycles; row sequence 0..7 wraps to 0.
REQ-035 enable dropped mid-SHIFT of row 3 plane 1 -> completes that ON (32 cycles) then IDLE blank=1; re-enable -> restart row 0 plane 0 with frame_start.
REQ-036 rst pulsed mid-ON -> next cycle all outputs at REQ-027 values; BCM_SCAN_BCM_EN undefined build -> frame_start period 2192 cycles, plane always 0.
